// File: rtl/gpio_in_pkg.sv
// Shared definitions for the GPIO input reader: register map, bus width, counter sizing.
// Latency: n/a (package).
// Backpressure: n/a (package).
package gpio_in_pkg;

    localparam int GPIO_IN_DW = 32;

    typedef enum logic [1:0] {
        GPIO_IN_STATE  = 2'd0,
        GPIO_IN_RISE   = 2'd1,
        GPIO_IN_FALL   = 2'd2,
        GPIO_IN_IRQ_EN = 2'd3
    } gpio_in_reg_e;

    // Width of a counter that must reach cycles-1.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/gpio_in_debounce.sv
// One input line: 2-flop synchroniser then debouncer (GPIO_IN_DEBOUNCE_EN) or plain register.
// Latency: stable follows pin 2+DEBOUNCE_CYCLES cycles later (3 cycles without the macro).
// Backpressure: none; rise/fall pulse in the cycle before stable changes.
module gpio_in_debounce
    import gpio_in_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic stable,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic upd;

    if (DEBOUNCE_CYCLES < 2) begin : g_param_check
        $error("gpio_in_debounce: DEBOUNCE_CYCLES must be at least 2");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= pin;
            sync <= meta;
        end
    end

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign upd = (sync != stable) && (cnt == CNT_LAST);

    // Any return to the stable level restarts the count from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (upd) begin
            stable <= sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
`else
    assign upd = (sync != stable);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
        end else begin
            stable <= sync;
        end
    end
`endif

    assign rise = upd & sync;
    assign fall = upd & ~sync;

endmodule

// File: rtl/gpio_in_reader.sv
// Four-register GPIO input slave: STATE, RISE/FALL sticky W1C flags, IRQ_EN; debounce via GPIO_IN_DEBOUNCE_EN.
// Latency: ready/rdata one cycle after valid; irq one cycle after a flag changes.
// Backpressure: ready <= valid & ~ready, so held requests ack every other cycle.
module gpio_in_reader
    import gpio_in_pkg::*;
#(
    parameter int N_IN            = 21,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN-1:0]       pin_in,
    input  logic                  valid,
    input  logic [1:0]            address,
    input  logic [GPIO_IN_DW-1:0] wdata,
    input  logic [3:0]            wstrb,
    output logic [GPIO_IN_DW-1:0] rdata,
    output logic                  ready,
    output logic                  irq
);

    localparam logic [GPIO_IN_DW-1:0] LINE_MASK = GPIO_IN_DW'((64'd1 << N_IN) - 64'd1);

    logic [N_IN-1:0]       stable_l;
    logic [N_IN-1:0]       rise_l;
    logic [N_IN-1:0]       fall_l;
    logic [GPIO_IN_DW-1:0] state_w;
    logic [GPIO_IN_DW-1:0] rise_set;
    logic [GPIO_IN_DW-1:0] fall_set;
    logic [GPIO_IN_DW-1:0] rise_clr;
    logic [GPIO_IN_DW-1:0] fall_clr;
    logic [GPIO_IN_DW-1:0] rise_q;
    logic [GPIO_IN_DW-1:0] fall_q;
    logic [GPIO_IN_DW-1:0] irq_en_q;
    logic [GPIO_IN_DW-1:0] rd_mux;
    logic                  access;
    logic                  wr;

    for (genvar i = 0; i < N_IN; i++) begin : g_line
        gpio_in_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_line (
            .clk   (clk),
            .rst_n (rst_n),
            .pin   (pin_in[i]),
            .stable(stable_l[i]),
            .rise  (rise_l[i]),
            .fall  (fall_l[i])
        );
    end

    // Widen per-line vectors to the bus; bits above N_IN stay zero.
    always_comb begin
        state_w                = '0;
        rise_set               = '0;
        fall_set               = '0;
        state_w[N_IN-1:0]      = stable_l;
        rise_set[N_IN-1:0]     = rise_l;
        fall_set[N_IN-1:0]     = fall_l;
    end

    assign access = valid & ~ready;
    assign wr     = access & (|wstrb);

    always_comb begin
        rise_clr = '0;
        fall_clr = '0;
        if (wr && (address == GPIO_IN_RISE)) rise_clr = wdata & LINE_MASK;
        if (wr && (address == GPIO_IN_FALL)) fall_clr = wdata & LINE_MASK;
    end

    always_comb begin
        rd_mux = '0;
        case (gpio_in_reg_e'(address))
            GPIO_IN_STATE:  rd_mux = state_w;
            GPIO_IN_RISE:   rd_mux = rise_q;
            GPIO_IN_FALL:   rd_mux = fall_q;
            GPIO_IN_IRQ_EN: rd_mux = irq_en_q;
            default:        rd_mux = '0;
        endcase
    end

    // A new edge is OR-ed in after the clear, so set wins on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q   <= '0;
            fall_q   <= '0;
            irq_en_q <= '0;
            rdata    <= '0;
            ready    <= 1'b0;
            irq      <= 1'b0;
        end else begin
            ready  <= access;
            if (access) rdata <= rd_mux;
            rise_q <= (rise_q & ~rise_clr) | rise_set;
            fall_q <= (fall_q & ~fall_clr) | fall_set;
            if (wr && (address == GPIO_IN_IRQ_EN)) irq_en_q <= wdata & LINE_MASK;
            irq    <= |((rise_q | fall_q) & irq_en_q);
        end
    end

endmodule

// File: tb/tb_gpio_in_reader.sv
// Directed bench for gpio_in_reader with N_IN=4, DEBOUNCE_CYCLES=8, either setting of GPIO_IN_DEBOUNCE_EN.
module tb_gpio_in_reader;
    import gpio_in_pkg::*;

    localparam int N  = 4;
    localparam int DC = 8;
`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int LAT = 2 + DC;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [N-1:0] pin_in;
    logic        valid;
    logic [1:0]  address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] r;
    logic        ia;
    int          n;
    int          bad;

    typedef struct packed {
        logic [1:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [11];

    gpio_in_reader #(.N_IN(N), .DEBOUNCE_CYCLES(DC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_in (pin_in),
        .valid  (valid),
        .address(address),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .rdata  (rdata),
        .ready  (ready),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int cnt);
        repeat (cnt) @(posedge clk);
        #1;
    endtask

    // Entered 1 ns after a rising edge; leaves 1 ns after the edge following the ack.
    task automatic bus(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output logic irq_ack);
        valid   = 1'b1;
        address = a;
        wdata   = d;
        wstrb   = s;
        @(negedge clk);
        chk("ready_before_ack", {31'b0, ready}, 32'd0);
        @(negedge clk);
        chk("ready_ack", {31'b0, ready}, 32'd1);
        rd      = rdata;
        irq_ack = irq;
        @(posedge clk);
        #1;
        valid = 1'b0;
        wstrb = 4'h0;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
        logic [31:0] v;
        logic        q;
        bus(a, 32'h0, 4'h0, v, q);
        chk(name, v, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] v;
        logic        q;
        bus(a, d, 4'hF, v, q);
    endtask

    // n = number of rising edges between the call and the first negedge with irq high.
    task automatic wait_irq(input int budget, output int cnt);
        cnt = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (irq === 1'b1) begin
                cnt = k;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{GPIO_IN_IRQ_EN, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[1]  = '{GPIO_IN_IRQ_EN, 32'h0,         4'h0, 32'h0000_000F};
        tbl[2]  = '{GPIO_IN_STATE,  32'h0,         4'hF, 32'h0};
        tbl[3]  = '{GPIO_IN_STATE,  32'h0,         4'h0, 32'h0000_000F};
        tbl[4]  = '{GPIO_IN_IRQ_EN, 32'h0000_0005, 4'h1, 32'h0};
        tbl[5]  = '{GPIO_IN_IRQ_EN, 32'h0,         4'h0, 32'h0000_0005};
        tbl[6]  = '{GPIO_IN_RISE,   32'h0,         4'h0, 32'h0};
        tbl[7]  = '{GPIO_IN_FALL,   32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[8]  = '{GPIO_IN_FALL,   32'h0,         4'h0, 32'h0};
        tbl[9]  = '{GPIO_IN_IRQ_EN, 32'hFFFF_FFF0, 4'hF, 32'h0};
        tbl[10] = '{GPIO_IN_IRQ_EN, 32'h0,         4'h0, 32'h0};

        rst_n   = 1'b0;
        pin_in  = '0;
        valid   = 1'b0;
        address = 2'd0;
        wdata   = 32'h0;
        wstrb   = 4'h0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Reset asserted mid-count with all inputs high.
        wr(GPIO_IN_IRQ_EN, 32'hF);
        pin_in = 4'hF;
        tick(5);
        rd_chk(GPIO_IN_STATE, (LAT <= 5) ? 32'hF : 32'h0, "state_before_reset");
        chk("irq_before_reset", {31'b0, irq}, (LAT <= 5) ? 32'd1 : 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("irq_in_reset", {31'b0, irq}, 32'd0);
        chk("ready_in_reset", {31'b0, ready}, 32'd0);
        chk("rdata_in_reset", rdata, 32'h0);
        pin_in = 4'h0;
        tick(2);
        rst_n = 1'b1;
        rd_chk(GPIO_IN_STATE,  32'h0, "reset_state");
        rd_chk(GPIO_IN_RISE,   32'h0, "reset_rise");
        rd_chk(GPIO_IN_FALL,   32'h0, "reset_fall");
        rd_chk(GPIO_IN_IRQ_EN, 32'h0, "reset_irq_en");

        // Release with lines high: RISE after the input latency.
        rst_n  = 1'b0;
        pin_in = 4'hF;
        tick(2);
        rst_n = 1'b1;
        wr(GPIO_IN_IRQ_EN, 32'hF);
        wait_irq(40, n);
        chk("release_irq_latency", 32'(n), 32'(LAT - 1));
        rd_chk(GPIO_IN_STATE, 32'hF, "release_state");
        rd_chk(GPIO_IN_RISE,  32'hF, "release_rise");
        rd_chk(GPIO_IN_FALL,  32'h0, "release_fall");
        bus(GPIO_IN_RISE, 32'hF, 4'hF, r, ia);
        chk("w1c_irq_at_ack", {31'b0, ia}, 32'd1);
        chk("w1c_irq_after", {31'b0, irq}, 32'd0);

        // Register access table.
        for (int i = 0; i < 11; i++) begin
            bus(tbl[i].a, tbl[i].d, tbl[i].s, r, ia);
            if (tbl[i].s == 4'h0) chk($sformatf("tbl_%0d", i), r, tbl[i].exp);
        end

        // Held request: ack every other cycle.
        valid   = 1'b1;
        address = GPIO_IN_STATE;
        wstrb   = 4'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready_%0d", i), {31'b0, ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            @(posedge clk);
        end
        #1;
        valid = 1'b0;
        tick(1);

        // Edges and interrupt on line 1.
        pin_in = 4'h0;
        tick(LAT + 3);
        wr(GPIO_IN_RISE, 32'hF);
        wr(GPIO_IN_FALL, 32'hF);
        wr(GPIO_IN_IRQ_EN, 32'h2);
        chk("edge_irq_idle", {31'b0, irq}, 32'd0);
        pin_in = 4'h2;
        wait_irq(40, n);
        chk("rise_irq_latency", 32'(n), 32'(LAT + 1));
        rd_chk(GPIO_IN_RISE,  32'h2, "edge_rise");
        rd_chk(GPIO_IN_STATE, 32'h2, "edge_state");
        tick(20 - (LAT + 6));
        pin_in = 4'h0;
        tick(LAT + 2);
        rd_chk(GPIO_IN_FALL, 32'h2, "edge_fall");
        wr(GPIO_IN_RISE, 32'h2);
        rd_chk(GPIO_IN_RISE, 32'h0, "edge_rise_cleared");
        chk("irq_held_by_fall", {31'b0, irq}, 32'd1);
        bus(GPIO_IN_FALL, 32'h2, 4'hF, r, ia);
        chk("fall_clr_irq_at_ack", {31'b0, ia}, 32'd1);
        chk("fall_clr_irq_after", {31'b0, irq}, 32'd0);

        // Clear landing on the same edge that sets RISE[2].
        pin_in = 4'h4;
        tick(LAT - 1);
        wr(GPIO_IN_RISE, 32'h4);
        rd_chk(GPIO_IN_RISE, 32'h4, "collision_set_wins");
        wr(GPIO_IN_RISE, 32'h4);
        rd_chk(GPIO_IN_RISE, 32'h0, "collision_then_clear");

`ifdef GPIO_IN_DEBOUNCE_EN
        // Bouncing line 0 must not pass until it holds for the full window.
        wr(GPIO_IN_IRQ_EN, 32'h1);
        bad = 0;
        for (int t = 0; t < 30; t++) begin
            if (t % 3 == 0) pin_in[0] = ~pin_in[0];
            @(negedge clk);
            if (irq !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        chk("bounce_quiet", 32'(bad), 32'd0);
        rd_chk(GPIO_IN_STATE, 32'h4, "bounce_state_low");
        pin_in[0] = 1'b1;
        wait_irq(40, n);
        chk("bounce_irq_latency", 32'(n), 32'(LAT + 1));
        rd_chk(GPIO_IN_STATE, 32'h5, "bounce_state_high");
        rd_chk(GPIO_IN_RISE,  32'h1, "bounce_rise");
        rd_chk(GPIO_IN_FALL,  32'h0, "bounce_no_fall");
`else
        // Single-cycle pulse on line 3 passes straight through.
        wr(GPIO_IN_IRQ_EN, 32'h8);
        for (int off = 2; off <= 4; off++) begin
            pin_in[3] = 1'b1;
            tick(1);
            pin_in[3] = 1'b0;
            tick(off - 1);
            rd_chk(GPIO_IN_STATE, (off == 3) ? 32'hC : 32'h4, $sformatf("pulse_state_%0d", off));
            tick(3);
        end
        rd_chk(GPIO_IN_RISE, 32'h8, "pulse_rise");
        rd_chk(GPIO_IN_FALL, 32'h8, "pulse_fall");
        chk("pulse_irq", {31'b0, irq}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
